// File: rtl/addseq_arbiter_pkg.sv
// addseq_arbiter_pkg: shared FSM states and sizing constants for the nibble-serial adder arbiter.
package addseq_arbiter_pkg;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  localparam int NW = 4;
  localparam int NREQ = 2;
endpackage

// File: rtl/addseq_arbiter_add4.sv
// add4: combinational 4-bit adder with carry in and carry out.
module add4
  import addseq_arbiter_pkg::*;
(
  input  logic [NW-1:0] a,
  input  logic [NW-1:0] b,
  input  logic          cin,
  output logic [NW-1:0] sum,
  output logic          cout
);
  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{NW{1'b0}}, cin};
endmodule

// File: rtl/addseq_arbiter.sv
// addseq_arbiter: two-requester arbiter sharing one 4-bit adder, adding one nibble per cycle.
module addseq_arbiter
  import addseq_arbiter_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req_i,
  input  logic [NW*NIBBLES-1:0]   a0_i,
  input  logic [NW*NIBBLES-1:0]   b0_i,
  input  logic [NW*NIBBLES-1:0]   a1_i,
  input  logic [NW*NIBBLES-1:0]   b1_i,
  output logic [NREQ-1:0]         gnt_o,
  output logic                    busy_o,
  output logic [NREQ-1:0]         done_o,
  output logic [NW*NIBBLES-1:0]   sum_o,
  output logic                    cout_o,
  output logic                    ovf_o
);
  localparam int W = NW * NIBBLES;
  localparam int CW = NIBBLES > 1 ? $clog2(NIBBLES) : 1;
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic [W-1:0] a_r, b_r, sum_r;
  logic [NW-1:0] nib_sum;
  logic [NREQ-1:0] gnt;
  logic carry, nib_cout, last, win, accept;
  // last holds the most recent winner, so it doubles as the grant register
  assign win = req_i[1] & (~req_i[0] | ~last);
  assign accept = state == IDLE && |req_i;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = |req_i ? CALC : IDLE;
      CALC: state_nx = cnt == CW'(NIBBLES - 1) ? DONE : CALC;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      a_r <= '0;
      b_r <= '0;
      sum_r <= '0;
      cnt <= '0;
      carry <= 1'b0;
      last <= 1'b1;
    end else if (accept) begin
      a_r <= win ? a1_i : a0_i;
      b_r <= win ? b1_i : b0_i;
      cnt <= '0;
      carry <= 1'b0;
      last <= win;
    end else if (state == CALC) begin
      sum_r[cnt*NW +: NW] <= nib_sum;
      carry <= nib_cout;
      cnt <= cnt + 1'b1;
    end
  add4 u_add4 (
    .a(a_r[cnt*NW +: NW]),
    .b(b_r[cnt*NW +: NW]),
    .cin(carry),
    .sum(nib_sum),
    .cout(nib_cout)
  );
  assign gnt = last ? 2'b10 : 2'b01;
  assign gnt_o = state == IDLE ? '0 : gnt;
  assign done_o = state == DONE ? gnt : '0;
  assign busy_o = state != IDLE;
  assign sum_o = sum_r;
  assign cout_o = carry;
  assign ovf_o = (a_r[W-1] == b_r[W-1]) & (sum_r[W-1] != a_r[W-1]);
endmodule

// File: tb/tb_addseq_arbiter.sv
// tb_addseq_arbiter: table vectors, directed corner sequences and randomized ops against an arithmetic model.
module tb_addseq_arbiter;
  typedef struct {
    logic [1:0]  req;
    logic [15:0] a0, b0, a1, b1;
    logic [1:0]  gnt;
    logic [15:0] sum;
    logic        cout, ovf;
  } vec_t;
  logic clk = 0, rst_n = 0;
  logic [1:0] req = 0;
  logic [15:0] a0 = 0, b0 = 0, a1 = 0, b1 = 0;
  logic [1:0] gnt_o, done_o;
  logic busy_o, cout_o, ovf_o;
  logic [15:0] sum_o;
  int total = 0, bad = 0;
  bit mdl_last = 1;
  vec_t tbl[7];
  addseq_arbiter #(.NIBBLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .req_i(req),
    .a0_i(a0), .b0_i(b0), .a1_i(a1), .b1_i(b1),
    .gnt_o(gnt_o), .busy_o(busy_o), .done_o(done_o),
    .sum_o(sum_o), .cout_o(cout_o), .ovf_o(ovf_o)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
    end
  endtask
  task automatic chk_zero(input string nm);
    chk({nm, " gnt"}, gnt_o, 0);
    chk({nm, " done"}, done_o, 0);
    chk({nm, " busy"}, busy_o, 0);
    chk({nm, " sum"}, sum_o, 0);
    chk({nm, " cout"}, cout_o, 0);
    chk({nm, " ovf"}, ovf_o, 0);
  endtask
  // caller drives inputs while the DUT is idle; keep leaves req/operands untouched after accept
  task automatic run_op(input logic [1:0] eg, input logic [15:0] es, input logic ec, input logic eo, input bit keep);
    int n;
    @(posedge clk); #1;
    chk("accept gnt", gnt_o, eg);
    chk("accept busy", busy_o, 1);
    if (!keep) begin
      req = 0; a0 = 16'($urandom); b0 = 16'($urandom); a1 = 16'($urandom); b1 = 16'($urandom);
    end
    n = 0;
    do begin @(posedge clk); #1; n++; end while (done_o == 0 && n < 8);
    chk("latency", n, 4);
    chk("done", done_o, eg);
    chk("sum", sum_o, es);
    chk("cout", cout_o, ec);
    chk("ovf", ovf_o, eo);
    chk("done gnt", gnt_o, eg);
    @(posedge clk); #1;
    chk("idle busy", busy_o, 0);
    chk("idle gnt", gnt_o, 0);
    chk("idle done", done_o, 0);
    chk("hold sum", sum_o, es);
    chk("hold cout", cout_o, ec);
    chk("hold ovf", ovf_o, eo);
    mdl_last = eg == 2'b10;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end
  initial begin
    int bc;
    bit g1;
    logic [1:0] eg;
    logic [15:0] a, b, es;
    int s;
    tbl[0] = '{2'b01, 16'h1234, 16'h4321, 16'h0000, 16'h0000, 2'b01, 16'h5555, 1'b0, 1'b0};
    tbl[1] = '{2'b10, 16'h0000, 16'h0000, 16'hFFFF, 16'h0001, 2'b10, 16'h0000, 1'b1, 1'b0};
    tbl[2] = '{2'b01, 16'h7FFF, 16'h0001, 16'h0000, 16'h0000, 2'b01, 16'h8000, 1'b0, 1'b1};
    tbl[3] = '{2'b01, 16'h8000, 16'h8000, 16'h0000, 16'h0000, 2'b01, 16'h0000, 1'b1, 1'b1};
    tbl[4] = '{2'b11, 16'h0001, 16'h0001, 16'h00F0, 16'h0F10, 2'b10, 16'h1000, 1'b0, 1'b0};
    tbl[5] = '{2'b11, 16'h4000, 16'h4000, 16'hFFFF, 16'hFFFF, 2'b01, 16'h8000, 1'b0, 1'b1};
    tbl[6] = '{2'b10, 16'h0000, 16'h0000, 16'h8001, 16'hFFFF, 2'b10, 16'h8000, 1'b1, 1'b0};
    req = 2'b11;
    #1 chk_zero("reset");
    repeat (2) @(posedge clk);
    #1 chk_zero("reset held");
    a0 = 16'h0102; b0 = 16'h0304; a1 = 16'h1111; b1 = 16'h2222;
    rst_n = 1;
    run_op(2'b01, 16'h0406, 0, 0, 1);
    run_op(2'b10, 16'h3333, 0, 0, 1);
    run_op(2'b01, 16'h0406, 0, 0, 0);
    foreach (tbl[i]) begin
      req = tbl[i].req; a0 = tbl[i].a0; b0 = tbl[i].b0; a1 = tbl[i].a1; b1 = tbl[i].b1;
      run_op(tbl[i].gnt, tbl[i].sum, tbl[i].cout, tbl[i].ovf, 0);
    end
    req = 2'b01; a0 = 16'hABCD; b0 = 16'h1111;
    @(posedge clk); #1;
    chk("abort accept", gnt_o, 2'b01);
    @(posedge clk); #1;
    rst_n = 0; req = 0;
    #1 chk_zero("abort");
    repeat (3) begin
      @(posedge clk); #1;
      chk("abort done", done_o, 0);
    end
    rst_n = 1;
    mdl_last = 1;
    req = 2'b01; a0 = 16'h2222; b0 = 16'h3333;
    run_op(2'b01, 16'h5555, 0, 0, 0);
    req = 2'b01; a0 = 16'h00FF; b0 = 16'h0001;
    @(posedge clk); #1;
    chk("late accept", gnt_o, 2'b01);
    bc = busy_o; g1 = 0;
    for (int k = 1; k <= 9; k++) begin
      req = k == 1 ? 2'b10 : k == 3 ? 2'b00 : req;
      @(posedge clk); #1;
      bc += busy_o;
      g1 |= gnt_o[1];
    end
    chk("late busy cycles", bc, 5);
    chk("late no gnt1", g1, 0);
    chk("late sum", sum_o, 16'h0100);
    mdl_last = 0;
    for (int i = 0; i < 24; i++) begin
      req = 2'($urandom_range(1, 3));
      a0 = 16'($urandom); b0 = 16'($urandom); a1 = 16'($urandom); b1 = 16'($urandom);
      eg = req == 2'b11 ? (mdl_last ? 2'b01 : 2'b10) : req;
      a = eg[1] ? a1 : a0;
      b = eg[1] ? b1 : b0;
      s = int'(a) + int'(b);
      es = s[15:0];
      run_op(eg, es, s[16], a[15] == b[15] && es[15] != a[15], 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
